tx_unit: RTL and testbench
==========================

# tx_unit

UART transmitter for the serial link block. It serialises one 8-bit word per frame onto `data_tx`: a start bit, eight data bits LSB first, a parity slot and a stop bit. Baud rate and parity mode are selectable at run time. The block contains its own baud tick generator, so it needs only the 50 MHz system clock, and it reports progress through `active_flag` and `done_flag`.

## Interface
Parameters:
- CLK_HZ, 50_000_000, system clock frequency used to derive the baud divisors.

Ports:
- clock  in  1  system clock, 50 MHz, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- send  in  1  level request; while it is high, a frame starts at the next baud tick seen in IDLE.
- parity_type  in  2  00 = none, 01 = odd, 10 = even, 11 = none.
- baud_rate  in  2  00 = 2400, 01 = 4800, 10 = 9600, 11 = 19200 baud.
- data_in  in  8  word to transmit; sampled at frame start.
- data_tx  out  1  serial line; idles high.
- active_flag  out  1  high while a frame is on the line.
- done_flag  out  1  high after a frame completes; cleared when the next frame starts.

## Operation
- Baud generator:
  - Divisor N = CLK_HZ / baud, rounded: 20833, 10417, 5208 and 2604 cycles.
  - The counter runs 0..N-1. A one-cycle `tick` fires when it reaches N-1, and the counter wraps to 0.
  - If the counter is already ≥ N-1, for example after a divisor change, it ticks and wraps on the next cycle.
  - In IDLE, N follows the live `baud_rate`. During a frame, N uses the value latched at frame start.
- Parity bit:
  - Odd mode: set so that the ones in data plus parity total an odd number.
  - Even mode: set so that the total is even.
  - None modes (00/11): the slot transmits 1, so the frame length is always 11 bits.
- FSM states: IDLE, START, DATA, PARITY, STOP. All transitions happen only on `tick`.
  - IDLE: if `send` = 1, latch `data_in`, `parity_type` and `baud_rate`, compute the parity bit, then go to START. Otherwise stay in IDLE.
  - START → DATA, with bit index 0.
  - DATA → PARITY after bit index 7. Otherwise increment the bit index.
  - PARITY → STOP.
  - STOP → IDLE.
- Line level per state:
  - IDLE: `data_tx` = 1.
  - START: 0.
  - DATA: shift register bit[i], LSB first.
  - PARITY: the parity bit.
  - STOP: 1.
- Flags:
  - `active_flag` = 1 in START, DATA, PARITY and STOP.
  - `done_flag` is set when STOP → IDLE and cleared when IDLE → START.
- Latched frame data is immune to `data_in`, `parity_type` and `baud_rate` changes until the next frame start.
- If `send` is held high, frames repeat back-to-back, with exactly one bit period of idle between them. That is 12 bit periods per frame.
- If `send` drops mid-frame, the current frame still completes normally.

## Timing
- Reset (asynchronous, any time including mid-frame):
  - `data_tx` = 1, `active_flag` = 0, `done_flag` = 0.
  - State IDLE, baud counter 0, shift register 0.
- All outputs are registered. They update on the clock edge that consumes the tick, one cycle after the counter reaches N-1.
- First frame latency: with the counter at 0 and `send` rising, `data_tx` falls after at most N+1 clock cycles.
- Each bit is held for exactly N clock cycles.
- Full frame (start to end of stop) is 11·N cycles. At 9600 baud this is 57288 cycles = 1.1458 ms.
- `done_flag` rises on the same edge where `data_tx` enters IDLE and `active_flag` falls.
- A `send` pulse shorter than N cycles may be missed. Requesters must hold `send` until `active_flag` rises.

## Test plan
- Reset: hold `reset_n` = 0 for 100 ns -> `data_tx` = 1, `active_flag` = 0, `done_flag` = 0. Assert reset mid-frame -> same values immediately (asynchronous).
- 9600 baud, odd parity, `data_in` = 8'b10101010, `send` held from 100 ns:
  - Line reads 0,0,1,0,1,0,1,0,1,1,1 (start, data LSB first, parity 1, stop).
  - Each bit is 5208 cycles = 104.16 µs.
  - `active_flag` is high for 57288 cycles, then `done_flag` = 1.
- 19200 baud, even parity, same data:
  - Parity slot = 0.
  - Each bit is 2604 cycles.
  - With `send` held, the next start bit follows exactly 2604 idle cycles later.
- No parity (00 and 11), data 8'hFF -> parity slot 1, frame still 11 bits. 2400 baud -> bit = 20833 cycles.
- Mid-frame changes: alter `data_in`, `baud_rate` and `parity_type` during DATA -> the current frame is unchanged. The next frame uses the new values.
- `send` dropped after `active_flag` rises -> the frame completes, `done_flag` = 1 and stays high, and `data_tx` stays 1 with no new frame.

Source files
------------

// File: rtl/tx_unit.sv
// UART transmitter: start, 8 data bits LSB first, parity slot, stop.
// Runtime-selectable baud (2400..19200) from an internal tick generator.
module tx_unit #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  input  logic [7:0] data_in,
  output logic       data_tx,
  output logic       active_flag,
  output logic       done_flag
);

  localparam int DIV0 = (CLK_HZ + 1200) / 2400;
  localparam int DIV1 = (CLK_HZ + 2400) / 4800;
  localparam int DIV2 = (CLK_HZ + 4800) / 9600;
  localparam int DIV3 = (CLK_HZ + 9600) / 19200;
  localparam int CW   = $clog2(DIV0);

  // Terminal counts (N-1) so the widest divisor always fits in CW bits.
  localparam logic [CW-1:0] TOP0 = CW'(DIV0 - 1);
  localparam logic [CW-1:0] TOP1 = CW'(DIV1 - 1);
  localparam logic [CW-1:0] TOP2 = CW'(DIV2 - 1);
  localparam logic [CW-1:0] TOP3 = CW'(DIV3 - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]    state, state_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_bit, par_n;
  logic [1:0]    baud_lat, baud_sel;
  logic [CW-1:0] cnt, top;
  logic          tick, line_n, start_frame;

  // Divisor tracks the live input only while idle.
  assign baud_sel = (state == IDLE) ? baud_rate : baud_lat;

  always_comb begin
    case (baud_sel)
      2'd0:    top = TOP0;
      2'd1:    top = TOP1;
      2'd2:    top = TOP2;
      default: top = TOP3;
    endcase
  end

  // >= so a counter stranded above a newly shortened divisor wraps at once.
  assign tick        = (cnt >= top);
  assign start_frame = tick && (state == IDLE) && send;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    shreg_n = shreg;
    par_n   = par_bit;
    if (tick) begin
      case (state)
        IDLE: if (send) begin
          state_n = START;
          shreg_n = data_in;
          case (parity_type)
            2'b01:   par_n = ~^data_in;
            2'b10:   par_n = ^data_in;
            default: par_n = 1'b1;
          endcase
        end
        START: begin
          state_n = DATA;
          idx_n   = 3'd0;
        end
        DATA: begin
          if (idx == 3'd7) state_n = PARITY;
          else             idx_n   = idx + 3'd1;
        end
        PARITY:  state_n = STOP;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    case (state_n)
      START:   line_n = 1'b0;
      DATA:    line_n = shreg_n[idx_n];
      PARITY:  line_n = par_n;
      default: line_n = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      state       <= IDLE;
      idx         <= 3'd0;
      shreg       <= 8'd0;
      par_bit     <= 1'b0;
      baud_lat    <= 2'd0;
      data_tx     <= 1'b1;
      active_flag <= 1'b0;
      done_flag   <= 1'b0;
    end else begin
      cnt         <= tick ? '0 : cnt + 1'b1;
      state       <= state_n;
      idx         <= idx_n;
      shreg       <= shreg_n;
      par_bit     <= par_n;
      data_tx     <= line_n;
      active_flag <= (state_n != IDLE);
      if (start_frame) baud_lat <= baud_rate;
      if (start_frame)                      done_flag <= 1'b0;
      else if (tick && (state == STOP))     done_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_unit.sv
// Scoreboard bench for tx_unit: randomized frames, bit-level line checks,
// back-to-back gap, flag behaviour and asynchronous reset.
module tb_tx_unit;
  localparam int CLK_HZ = 96000;   // divisors 40/20/10/5 keep runs short
  localparam int NMAX   = 40;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       send = 1'b0;
  logic [1:0] parity_type = 2'd0;
  logic [1:0] baud_rate = 2'd0;
  logic [7:0] data_in = 8'd0;
  logic       data_tx, active_flag, done_flag;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  typedef struct {
    logic [10:0] bits;
    int          n;
    bit          b2b;
  } exp_t;
  exp_t exp_q[$];

  tx_unit #(.CLK_HZ(CLK_HZ)) dut (
    .clock(clock), .reset_n(reset_n), .send(send), .parity_type(parity_type),
    .baud_rate(baud_rate), .data_in(data_in), .data_tx(data_tx),
    .active_flag(active_flag), .done_flag(done_flag)
  );

  always #10 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int div_of(input logic [1:0] b);
    int baud;
    baud = 2400 << b;
    return (CLK_HZ + baud / 2) / baud;
  endfunction

  function automatic logic [10:0] frame_of(input logic [7:0] d, input logic [1:0] p);
    logic pb;
    int   ones;
    ones = $countones(d);
    case (p)
      2'b01:   pb = (ones % 2 == 0);
      2'b10:   pb = (ones % 2 == 1);
      default: pb = 1'b1;
    endcase
    return {1'b1, pb, d, 1'b0};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: pops one expectation per frame and checks every bit's edges and middle.
  initial begin
    exp_t e;
    int   t, k, r, fall_cyc;
    bit   in_frame, prev_act;
    t = 0; k = 0; r = 0; fall_cyc = 0; in_frame = 0; prev_act = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        in_frame = 0;
        prev_act = 0;
        continue;
      end
      if (active_flag && !prev_act) begin
        if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
        else begin
          e = exp_q.pop_front();
          in_frame = 1;
          t = 0;
          check("done_clear", done_flag, 0);
          if (e.b2b) check("idle_gap", cyc - fall_cyc, e.n);
        end
      end
      if (in_frame) begin
        if (!active_flag) begin
          check("frame_len", t, 11 * e.n);
          check("done_set", done_flag, 1);
          check("idle_line", data_tx, 1);
          in_frame = 0;
          fall_cyc = cyc;
        end else begin
          k = t / e.n;
          r = t % e.n;
          if (k < 11 && (r == 0 || r == e.n / 2 || r == e.n - 1))
            check($sformatf("bit%0d", k), data_tx, e.bits[k]);
          t++;
        end
      end
      prev_act = active_flag;
    end
  end

  task automatic wait_act(input bit val, input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (active_flag == val) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Directed frames: {data, parity, baud, keep send high}
  logic [7:0] dir_d [4] = '{8'hAA, 8'hAA, 8'hFF, 8'hFF};
  logic [1:0] dir_p [4] = '{2'b01, 2'b10, 2'b00, 2'b11};
  logic [1:0] dir_b [4] = '{2'b10, 2'b11, 2'b00, 2'b01};
  bit         dir_k [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    exp_t       e;
    logic [7:0] d;
    logic [1:0] p, b;
    bit         keep, prev_keep, ok, bad, abort;
    localparam int NF = 16;
    prev_keep = 0; abort = 0;

    #100;
    check("rst_tx", data_tx, 1);
    check("rst_active", active_flag, 0);
    check("rst_done", done_flag, 0);
    reset_n = 1'b1;

    for (int f = 0; f < NF && !abort; f++) begin
      if (f < 4) begin
        d = dir_d[f]; p = dir_p[f]; b = dir_b[f]; keep = dir_k[f];
      end else begin
        d = 8'($urandom_range(0, 255));
        p = 2'($urandom_range(0, 3));
        b = 2'($urandom_range(0, 3));
        keep = ($urandom_range(0, 1) == 1) && (f != NF - 1);
      end
      data_in = d; parity_type = p; baud_rate = b; send = 1'b1;
      e.bits = frame_of(d, p);
      e.n    = div_of(b);
      e.b2b  = prev_keep;
      exp_q.push_back(e);

      wait_act(1'b1, e.n + 2, ok);
      check("start_latency", ok, 1);
      if (!ok) begin abort = 1; break; end

      repeat (2 * e.n) @(negedge clock);
      data_in = 8'($urandom_range(0, 255));
      parity_type = 2'($urandom_range(0, 3));
      baud_rate = 2'($urandom_range(0, 3));
      if (!keep) send = 1'b0;

      wait_act(1'b0, 9 * e.n + 4, ok);
      check("frame_end", ok, 1);
      if (!ok) begin abort = 1; break; end

      if (!keep) begin
        bad = 0;
        repeat (3 * NMAX) begin
          @(negedge clock);
          if (active_flag || !data_tx || !done_flag) bad = 1;
        end
        check("idle_hold", bad, 0);
      end
      prev_keep = keep;
    end

    if (!abort) begin
      // Asynchronous reset in the middle of a frame.
      data_in = 8'h3C; parity_type = 2'b01; baud_rate = 2'b10; send = 1'b1;
      e.bits = frame_of(8'h3C, 2'b01); e.n = div_of(2'b10); e.b2b = 0;
      exp_q.push_back(e);
      wait_act(1'b1, e.n + 2, ok);
      check("start_latency_rst", ok, 1);
      repeat (3 * e.n) @(negedge clock);
      #3 reset_n = 1'b0;
      #1;
      check("midrst_tx", data_tx, 1);
      check("midrst_active", active_flag, 0);
      check("midrst_done", done_flag, 0);
      send = 1'b0;
      repeat (3) @(negedge clock);
      exp_q.delete();
      reset_n = 1'b1;
      bad = 0;
      repeat (2 * NMAX) begin
        @(negedge clock);
        if (active_flag || !data_tx || done_flag) bad = 1;
      end
      check("post_rst_idle", bad, 0);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
